muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
Iterative multiply/divide sequencer in the EX stage, beside the single-cycle ALU. It accepts mult/multu/div/divu from the pipeline and runs a one-bit-per-cycle shift-add or shift-subtract for 32 cycles. It owns the architectural HI/LO registers and asserts a busy stall to the hazard unit until the result is committed. It also services mthi/mtlo writes.

Parameters:
WIDTH, 32, operand width; HI/LO width; iteration count equals WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
StartE  input  1  launch op; sampled only in IDLE
MDOpE  input  2  00 mult, 01 multu, 10 div, 11 divu
SrcAE  input  WIDTH  multiplicand/dividend; also mthi/mtlo data
SrcBE  input  WIDTH  multiplier/divisor
HiWrE  input  1  mthi: HI <= SrcAE
LoWrE  input  1  mtlo: LO <= SrcAE
AbortE  input  1  pipeline flush; cancel in-flight op
HiOut  output  WIDTH  HI register
LoOut  output  WIDTH  LO register
BusyE  output  1  high while state != IDLE
DoneE  output  1  one-cycle pulse after HI/LO commit or div-by-zero
DivZeroE  output  1  one-cycle pulse, coincident with DoneE, on div/divu with SrcBE==0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; HiOut, LoOut, all working regs, count = 0; BusyE=DoneE=DivZeroE=0. Reset mid-operation discards the op immediately.
- States: IDLE, ITER, FIX.
- IDLE:
  - StartE=1 with a valid op latches operand magnitudes, sign flags, and op into working regs, clears count, and goes to ITER at edge E0.
  - Signed ops use |SrcAE| and |SrcBE|. Magnitude of 0x80000000 is 0x80000000 unsigned.
  - StartE has priority: if StartE=1, HiWrE and LoWrE are ignored that cycle.
  - Otherwise HiWrE/LoWrE update HI/LO at the edge, and both may be set together.
- Div by zero: div/divu with SrcBE==0 at start does not enter ITER. State stays IDLE, HI/LO are unchanged, and DoneE=DivZeroE=1 for the cycle after E0.
- ITER, one step per edge, count 0..31:
  - Multiply: 64-bit shift-add, one multiplier bit per step.
  - Divide: restoring shift-subtract; remainder reg is WIDTH+1 bits, one quotient bit per step.
  - At the edge with count==31, go to FIX. That is edge E32; ITER takes 32 edges.
- FIX (edge E33):
  - Apply sign correction. Signed mult: negate the 64-bit product if signA^signB. Signed div: quotient negated if signA^signB; remainder takes the sign of the dividend.
  - Write HI=product[63:32]/remainder and LO=product[31:0]/quotient.
  - DoneE=1 for the following cycle; state returns to IDLE.
- Latency:
  - BusyE is high for exactly 33 cycles (after E0 through E33).
  - HI/LO are valid and DoneE is high in the cycle after E33.
  - A new StartE may be sampled in that same cycle.
- While BusyE=1: StartE, HiWrE and LoWrE are ignored, and HI/LO hold their old values.
- AbortE=1 in ITER or FIX: state goes to IDLE at the next edge, HI/LO are unchanged, and no DoneE pulse. AbortE in IDLE has no effect. AbortE and StartE together in IDLE: start wins.
- Width and overflow:
  - All arithmetic is modulo 2^WIDTH per half.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, with no exception.
  - Unsigned results are never sign-corrected.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- multu 0xFFFFFFFF*0xFFFFFFFF -> BusyE high 33 cycles, then DoneE pulse; HI=0xFFFFFFFE, LO=0x00000001.
- mult 0xFFFFFFFD(-3)*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then mult 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- divu 100/7 -> LO=14, HI=2. div 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- div 5/0 with prior HI=0x11, LO=0x22 -> DoneE=DivZeroE=1 in the next cycle, BusyE never high, HI/LO unchanged.
- Start divu, then AbortE at cycle 10 -> BusyE drops next cycle, no DoneE, HI/LO unchanged. Repeat with rst_n pulled low at cycle 20 -> all outputs 0 immediately.
- Interactions:
  - mthi 0xAAAA with StartE=0 -> HI=0xAAAA next cycle.
  - HiWrE and StartE together -> HI is not written by HiWrE.
  - HiWrE or StartE while BusyE=1 -> ignored.
  - Back-to-back StartE in the DoneE cycle -> second op is accepted.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Iterative mult/div sequencer owning HI/LO: launch edge, 32 ITER edges, 1 FIX edge, DoneE the cycle after.
// No handshake: BusyE stalls the pipeline, and StartE/HiWrE/LoWrE are ignored while busy.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StartE,
  input  logic [1:0]       MDOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             HiWrE,
  input  logic             LoWrE,
  input  logic             AbortE,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             BusyE,
  output logic             DoneE,
  output logic             DivZeroE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_busy, r_done, r_divzero;
  logic             r_signed, r_is_div, r_sa, r_sb;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_wh;
  logic [WIDTH-1:0] r_wl;

  logic             w_signed, w_is_div, w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH+1:0] w_div_diff;
  logic             w_div_ok;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix, w_rem_fix;

  always_comb begin
    w_signed = ~MDOpE[0];
    w_is_div = MDOpE[1];
    w_neg_a  = w_signed & SrcAE[WIDTH-1];
    w_neg_b  = w_signed & SrcBE[WIDTH-1];
    w_mag_a  = w_neg_a ? ('0 - SrcAE) : SrcAE;
    w_mag_b  = w_neg_b ? ('0 - SrcBE) : SrcBE;
  end

  // Multiply: r_wh is the running high half, r_wl holds the multiplier and
  // collects the low product bits as they shift out of the adder.
  // Divide: r_wh is the partial remainder, r_wl shifts the dividend out and
  // the quotient bits in.
  always_comb begin
    w_mul_sum   = r_wh + (r_wl[0] ? {1'b0, r_b} : '0);
    w_div_shift = {r_wh[WIDTH-1:0], r_wl[WIDTH-1]};
    w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
    w_div_ok    = ~w_div_diff[WIDTH+1];
  end

  always_comb begin
    w_prod     = {r_wh[WIDTH-1:0], r_wl};
    w_prod_fix = (r_signed && (r_sa ^ r_sb)) ? ('0 - w_prod) : w_prod;
    w_quo_fix  = (r_signed && (r_sa ^ r_sb)) ? ('0 - r_wl) : r_wl;
    w_rem_fix  = (r_signed && r_sa) ? ('0 - r_wh[WIDTH-1:0]) : r_wh[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      r_signed  <= 1'b0;
      r_is_div  <= 1'b0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_b       <= '0;
      r_wh      <= '0;
      r_wl      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (StartE) begin
            if (w_is_div && (SrcBE == '0)) begin
              r_done    <= 1'b1;
              r_divzero <= 1'b1;
            end else begin
              r_state  <= S_ITER;
              r_busy   <= 1'b1;
              r_count  <= '0;
              r_signed <= w_signed;
              r_is_div <= w_is_div;
              r_sa     <= w_neg_a;
              r_sb     <= w_neg_b;
              r_b      <= w_is_div ? w_mag_b : w_mag_a;
              r_wl     <= w_is_div ? w_mag_a : w_mag_b;
              r_wh     <= '0;
            end
          end else begin
            if (HiWrE) r_hi <= SrcAE;
            if (LoWrE) r_lo <= SrcAE;
          end
        end
        S_ITER: begin
          if (AbortE) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_is_div) begin
              r_wh <= w_div_ok ? w_div_diff[WIDTH:0] : w_div_shift;
              r_wl <= {r_wl[WIDTH-2:0], w_div_ok};
            end else begin
              r_wh <= {1'b0, w_mul_sum[WIDTH:1]};
              r_wl <= {w_mul_sum[0], r_wl[WIDTH-1:1]};
            end
            r_count <= r_count + 1'b1;
            if (r_count == CW'(WIDTH - 1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!AbortE) begin
            r_done <= 1'b1;
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign HiOut    = r_hi;
  assign LoOut    = r_lo;
  assign BusyE    = r_busy;
  assign DoneE    = r_done;
  assign DivZeroE = r_divzero;

endmodule
